// File: rtl/board_scanner_if.sv
// Board scanner bus: scan request, board RAM read port and tally results.
interface board_scanner_if;
  logic        start;
  logic [9:0]  rd_addr;
  logic [3:0]  rd_data;
  logic        busy;
  logic        done;
  logic [10:0] pellet_count;
  logic [10:0] power_count;
  logic        board_clear;

  // Environment side: game control plus the board RAM data return.
  modport master (
    output start, rd_data,
    input  rd_addr, busy, done, pellet_count, power_count, board_clear
  );

  // Scanner side.
  modport slave (
    input  start, rd_data,
    output rd_addr, busy, done, pellet_count, power_count, board_clear
  );
endinterface

// File: rtl/board_scanner.sv
// Board scanner: sweeps the tile RAM read port once per start request and
// tallies pellet / power-pellet tiles into stable result registers.
module board_scanner #(
  parameter logic [9:0] LAST_ADDR   = 10'd1023,
  parameter logic [3:0] PELLET_CODE = 4'd1,
  parameter logic [3:0] POWER_CODE  = 4'd2
) (
  input  logic          clk,
  input  logic          reset,
  board_scanner_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic        vld_p1_q, vld_p1_d;
  logic [10:0] pel_acc_q, pel_acc_d;
  logic [10:0] pow_acc_q, pow_acc_d;
  logic [10:0] pel_cnt_q, pel_cnt_d;
  logic [10:0] pow_cnt_q, pow_cnt_d;
  logic        clear_q, clear_d;

  logic        pel_hit, pow_hit;
  logic [10:0] pel_sum, pow_sum;

  // Classify the returned tile; a code matching both parameters is a pellet.
  always_comb begin
    pel_hit = vld_p1_q && (bus.rd_data == PELLET_CODE);
    pow_hit = vld_p1_q && (bus.rd_data == POWER_CODE) &&
              (bus.rd_data != PELLET_CODE);
    pel_sum = pel_acc_q + {10'd0, pel_hit};
    pow_sum = pow_acc_q + {10'd0, pow_hit};
  end

  // Scan sequencing, address stepping and accumulation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    vld_p1_d  = 1'b0;
    pel_acc_d = pel_acc_q;
    pow_acc_d = pow_acc_q;
    pel_cnt_d = pel_cnt_q;
    pow_cnt_d = pow_cnt_q;
    clear_d   = clear_q;
    case (state_q)
      S_IDLE: begin
        addr_d = 10'd0;
        if (bus.start) begin
          state_d   = S_SCAN;
          pel_acc_d = 11'd0;
          pow_acc_d = 11'd0;
        end
      end
      S_SCAN: begin
        // Data for this cycle's address returns next cycle.
        vld_p1_d  = 1'b1;
        pel_acc_d = pel_sum;
        pow_acc_d = pow_sum;
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 10'd1;
        end
      end
      S_DRAIN: begin
        // Last tile arrives now; publish the finished totals in one step.
        pel_acc_d = pel_sum;
        pow_acc_d = pow_sum;
        pel_cnt_d = pel_sum;
        pow_cnt_d = pow_sum;
        clear_d   = (pel_sum == 11'd0) && (pow_sum == 11'd0);
        addr_d    = 10'd0;
        state_d   = S_DONE;
      end
      default: begin
        addr_d  = 10'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any prior results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= 10'd0;
      vld_p1_q  <= 1'b0;
      pel_acc_q <= 11'd0;
      pow_acc_q <= 11'd0;
      pel_cnt_q <= 11'd0;
      pow_cnt_q <= 11'd0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      vld_p1_q  <= vld_p1_d;
      pel_acc_q <= pel_acc_d;
      pow_acc_q <= pow_acc_d;
      pel_cnt_q <= pel_cnt_d;
      pow_cnt_q <= pow_cnt_d;
      clear_q   <= clear_d;
    end
  end

  assign bus.rd_addr      = addr_q;
  assign bus.busy         = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign bus.done         = (state_q == S_DONE);
  assign bus.pellet_count = pel_cnt_q;
  assign bus.power_count  = pow_cnt_q;
  assign bus.board_clear  = clear_q;

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: a 16-tile instance driven from a vector
// table plus hand sequences, and a full-size 1024-tile instance.
module tb_board_scanner;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  board_scanner_if bus1 ();
  board_scanner_if bus2 ();

  board_scanner #(.LAST_ADDR(10'd15)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  board_scanner dut_big (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // Board RAM models with one cycle of read latency.
  logic [3:0] mem [0:15];
  always_ff @(posedge clk) bus1.rd_data <= mem[bus1.rd_addr[3:0]];
  always_ff @(posedge clk) bus2.rd_data <= 4'd1;

  typedef struct {
    logic [63:0] codes;
    int          exp_pel;
    int          exp_pow;
    int          exp_clr;
  } vec_t;

  vec_t vecs [7];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] codes);
    for (int i = 0; i < 16; i++) mem[i] = codes[4*i +: 4];
  endtask

  // Pulse start, follow one scan for 40 cycles, check timing and results.
  task automatic run_scan(input string tag, input logic [63:0] codes,
                          input int ep, input int ew, input int ec);
    int c, done_at, ndone, addr_ok, hold_ok, prev_p, prev_w;
    load(codes);
    prev_p = bus1.pellet_count;
    prev_w = bus1.power_count;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    c = 1; done_at = 0; ndone = 0; addr_ok = 1; hold_ok = 1;
    while (c <= 40) begin
      if (c <= 16 && (bus1.rd_addr != 10'(c - 1) || !bus1.busy)) addr_ok = 0;
      if (bus1.rd_addr > 10'd15) addr_ok = 0;
      if (c <= 17 && (bus1.pellet_count != 11'(prev_p) ||
                      bus1.power_count != 11'(prev_w))) hold_ok = 0;
      if (bus1.done) begin
        if (done_at == 0) done_at = c;
        ndone++;
      end
      tick();
      c++;
    end
    chk({tag, " addr_seq"}, addr_ok, 1);
    chk({tag, " results_hold"}, hold_ok, 1);
    chk({tag, " done_cycle"}, done_at, 18);
    chk({tag, " done_pulses"}, ndone, 1);
    chk({tag, " pellet_count"}, bus1.pellet_count, ep);
    chk({tag, " power_count"}, bus1.power_count, ew);
    chk({tag, " board_clear"}, bus1.board_clear, ec);
  endtask

  initial begin
    int c, ndone, busy_after, d1, d2;

    vecs[0] = '{64'h2000_0010_1000_1000, 3, 1, 0};
    vecs[1] = '{64'h0000_0000_0000_0000, 0, 0, 1};
    vecs[2] = '{64'h0000_0000_0000_0001, 1, 0, 0};
    vecs[3] = '{64'h2000_0000_0000_0000, 0, 1, 0};
    vecs[4] = '{64'h1111_1111_1111_1111, 16, 0, 0};
    vecs[5] = '{64'h5252_5252_5252_5252, 0, 8, 0};
    vecs[6] = '{64'hFEDC_BA98_7654_3210, 1, 1, 0};

    load(64'h0);
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("idle busy", bus1.busy, 0);
    chk("idle done", bus1.done, 0);
    chk("idle pellet", bus1.pellet_count, 0);
    chk("idle power", bus1.power_count, 0);
    chk("idle clear", bus1.board_clear, 0);
    chk("idle rd_addr", bus1.rd_addr, 0);
    chk("idle big busy", bus2.busy, 0);

    for (int v = 0; v < 7; v++)
      run_scan($sformatf("vec%0d", v), vecs[v].codes,
               vecs[v].exp_pel, vecs[v].exp_pow, vecs[v].exp_clr);

    // Start held high: back-to-back scans with one idle cycle between.
    load(vecs[0].codes);
    bus1.start = 1'b1;
    tick();
    c = 1; d1 = 0; d2 = 0; ndone = 0;
    while (c <= 40) begin
      if (bus1.done) begin
        ndone++;
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (c == 19) chk("b2b idle gap busy", bus1.busy, 0);
      if (c == 20) chk("b2b rescan addr", bus1.rd_addr, 0);
      if (c == 20) chk("b2b rescan busy", bus1.busy, 1);
      tick();
      c++;
    end
    bus1.start = 1'b0;
    chk("b2b first done", d1, 18);
    chk("b2b second done", d2, 37);
    chk("b2b done count", ndone, 2);
    for (int i = 0; i < 25; i++) tick();
    chk("b2b pellet", bus1.pellet_count, 3);

    // Start re-pulsed mid-scan and in DONE is not queued.
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    c = 1; ndone = 0; busy_after = 0;
    while (c <= 45) begin
      bus1.start = (c == 5 || c == 17 || c == 18) ? 1'b1 : 1'b0;
      if (bus1.done) ndone++;
      if (c > 18 && bus1.busy) busy_after = 1;
      tick();
      c++;
    end
    bus1.start = 1'b0;
    chk("noqueue done count", ndone, 1);
    chk("noqueue no rescan", busy_after, 0);

    // Reset in the 8th scan cycle discards everything, no done pulse.
    load(vecs[4].codes);
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    chk("rst busy", bus1.busy, 0);
    chk("rst done", bus1.done, 0);
    chk("rst rd_addr", bus1.rd_addr, 0);
    chk("rst pellet", bus1.pellet_count, 0);
    chk("rst power", bus1.power_count, 0);
    chk("rst clear", bus1.board_clear, 0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus1.done || bus1.busy) ndone++;
      tick();
    end
    chk("rst no activity", ndone, 0);
    run_scan("post_rst", vecs[0].codes, 3, 1, 0);

    // Full-size board of pellets: 1024 fits the 11-bit count.
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    c = 1;
    while (!bus2.done && c < 1200) begin
      tick();
      c++;
    end
    chk("big done cycle", c, 1026);
    chk("big pellet", bus2.pellet_count, 1024);
    chk("big power", bus2.power_count, 0);
    chk("big clear", bus2.board_clear, 0);
    tick();
    chk("big done width", bus2.done, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
